// File: rtl/tdc_sweep_checker.sv
// Receive-side checker for the TDC hit-width sweep: verifies each sweep of fine
// codes is monotonic and gap-free, tracks code range, and reports a verdict.
module tdc_sweep_checker #(
    parameter int NUM_TAPS   = 240,
    parameter int CODE_W     = 9,
    parameter int MAX_DELTA  = 2,
    parameter int NUM_SWEEPS = 3,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              meas_valid,
    input  logic [CODE_W-1:0] meas_code,
    output logic              armed,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [CODE_W-1:0] min_code,
    output logic [CODE_W-1:0] max_code,
    output logic [2:0]        sweep_idx
);

    localparam int STEP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_TAPS - 1);
    localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]        SWEEPS_END = 3'(NUM_SWEEPS);
    localparam logic [CODE_W:0]   DELTA_LIM  = (CODE_W + 1)'(MAX_DELTA);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   prev_q, prev_d;
    logic [CODE_W-1:0]   min_q, min_d;
    logic [CODE_W-1:0]   max_q, max_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [15:0]         err_q, err_d;
    logic [2:0]          sweep_q, sweep_d;
    logic                timeout_q, timeout_d;
    logic                pass_q, pass_d;

    logic [CODE_W:0]     delta;
    logic                bad_step;
    logic                last_sample;
    logic                clear_all;

    // Extra MSB keeps a backward step from aliasing into a small forward delta.
    always_comb begin
        delta       = {1'b0, meas_code} - {1'b0, prev_q};
        bad_step    = (meas_code < prev_q) || (delta > DELTA_LIM);
        last_sample = (step_q == LAST_STEP);
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        min_d     = min_q;
        max_d     = max_q;
        step_d    = step_q;
        wd_d      = wd_q;
        err_d     = err_q;
        sweep_d   = sweep_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        clear_all = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clear_all = 1'b1;
                if (start) state_d = ST_ARMED;
            end
            ST_ARMED, ST_RUN: begin
                if (meas_valid) begin
                    // First sample of a sweep has no predecessor to compare with.
                    if ((state_q == ST_RUN) && bad_step && (err_q != 16'hFFFF))
                        err_d = err_q + 16'd1;
                    prev_d = meas_code;
                    if (meas_code < min_q) min_d = meas_code;
                    if (meas_code > max_q) max_d = meas_code;
                    wd_d = '0;
                    if (last_sample) begin
                        step_d  = '0;
                        sweep_d = sweep_q + 3'd1;
                        if (sweep_d == SWEEPS_END) begin
                            state_d = ST_DONE;
                            pass_d  = (err_d == 16'd0) && !timeout_q;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_RUN;
                    end
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    wd_d      = '0;
                    state_d   = ST_DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    clear_all = 1'b1;
                    state_d   = ST_ARMED;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            clear_all = 1'b1;
            state_d   = ST_IDLE;
        end

        if (clear_all) begin
            prev_d    = '0;
            min_d     = '1;
            max_d     = '0;
            step_d    = '0;
            wd_d      = '0;
            err_d     = '0;
            sweep_d   = '0;
            timeout_d = 1'b0;
            pass_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            min_q     <= '1;
            max_q     <= '0;
            step_q    <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            sweep_q   <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            min_q     <= min_d;
            max_q     <= max_d;
            step_q    <= step_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            sweep_q   <= sweep_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    assign armed     = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign min_code  = min_q;
    assign max_code  = max_q;
    assign sweep_idx = sweep_q;

endmodule

// File: tb/tb_tdc_sweep_checker.sv
// Bench for tdc_sweep_checker: directed scenarios plus randomized sweeps,
// scoreboarded against a sweep-level reference model.
module tb_tdc_sweep_checker;

    localparam int CODE_W     = 9;
    localparam int NUM_TAPS   = 4;
    localparam int MAX_DELTA  = 2;
    localparam int NUM_SWEEPS = 2;
    localparam int TIMEOUT    = 16;
    localparam int SAT_TAPS   = 70000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              meas_valid = 1'b0;
    logic [CODE_W-1:0] meas_code = '0;
    logic              armed, done, pass, timeout;
    logic [15:0]       err_count;
    logic [CODE_W-1:0] min_code, max_code;
    logic [2:0]        sweep_idx;

    logic              sat_start = 1'b0;
    logic              sat_abort = 1'b0;
    logic              sat_valid = 1'b0;
    logic [CODE_W-1:0] sat_code = '0;
    logic              sat_armed, sat_done, sat_pass, sat_timeout;
    logic [15:0]       sat_err;
    logic [CODE_W-1:0] sat_min, sat_max;
    logic [2:0]        sat_sweep;

    tdc_sweep_checker #(
        .NUM_TAPS(NUM_TAPS), .CODE_W(CODE_W), .MAX_DELTA(MAX_DELTA),
        .NUM_SWEEPS(NUM_SWEEPS), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .meas_valid(meas_valid), .meas_code(meas_code),
        .armed(armed), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .min_code(min_code), .max_code(max_code),
        .sweep_idx(sweep_idx)
    );

    tdc_sweep_checker #(
        .NUM_TAPS(SAT_TAPS), .CODE_W(CODE_W), .MAX_DELTA(MAX_DELTA),
        .NUM_SWEEPS(1), .TIMEOUT(4096)
    ) u_sat (
        .clk(clk), .rst(rst), .start(sat_start), .abort(sat_abort),
        .meas_valid(sat_valid), .meas_code(sat_code),
        .armed(sat_armed), .done(sat_done), .pass(sat_pass), .timeout(sat_timeout),
        .err_count(sat_err), .min_code(sat_min), .max_code(sat_max),
        .sweep_idx(sat_sweep)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // sample: {armed, sweep_idx, err_count, min_code, max_code}
    // verdict: {pass, timeout, err_count, min_code, max_code, sweep_idx}
    logic [37:0] samp_q[$];
    logic [38:0] verd_q[$];

    // Reference model state, in sweep-level terms.
    bit m_active = 0;
    bit m_first  = 1;
    bit m_to     = 0;
    int m_errs   = 0;
    int m_min    = 511;
    int m_max    = 0;
    int m_prev   = 0;
    int m_cnt    = 0;
    int m_sweeps = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] pack_samp();
        return {m_active, 3'(m_sweeps), 16'(m_errs), 9'(m_min), 9'(m_max)};
    endfunction

    function automatic logic [38:0] pack_verd();
        return {(m_errs == 0) && !m_to, m_to, 16'(m_errs), 9'(m_min), 9'(m_max), 3'(m_sweeps)};
    endfunction

    task automatic model_clear();
        m_first = 1; m_to = 0; m_errs = 0; m_min = 511; m_max = 0;
        m_prev = 0; m_cnt = 0; m_sweeps = 0;
    endtask

    task automatic model_sample(input int code);
        if (m_active) begin
            if (!m_first) begin
                if (code < m_prev || code - m_prev > MAX_DELTA)
                    m_errs = (m_errs < 65535) ? m_errs + 1 : 65535;
            end
            m_first = 0;
            m_prev  = code;
            if (code < m_min) m_min = code;
            if (code > m_max) m_max = code;
            m_cnt++;
            if (m_cnt == NUM_TAPS) begin
                m_cnt = 0;
                m_sweeps++;
                m_first = 1;
                if (m_sweeps == NUM_SWEEPS) begin
                    m_active = 0;
                    verd_q.push_back(pack_verd());
                end
            end
        end
        samp_q.push_back(pack_samp());
    endtask

    task automatic model_timeout();
        m_to = 1;
        m_active = 0;
        verd_q.push_back(pack_verd());
    endtask

    // Monitor: pops expectations whenever the DUT has consumed a sample or raised done.
    logic        vld_d = 1'b0;
    logic        done_prev = 1'b0;
    logic [37:0] es;
    logic [38:0] ev;
    always @(posedge clk) vld_d <= meas_valid;

    always @(negedge clk) begin
        if (vld_d) begin
            if (samp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL samp_q: DUT consumed a sample with no expectation queued");
            end else begin
                es = samp_q.pop_front();
                check("samp_armed", armed, es[37]);
                check("samp_sweep_idx", sweep_idx, es[36:34]);
                check("samp_err_count", err_count, es[33:18]);
                check("samp_min_code", min_code, es[17:9]);
                check("samp_max_code", max_code, es[8:0]);
            end
        end
        if (done && !done_prev) begin
            if (verd_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL verd_q: done rose with no verdict expected");
            end else begin
                ev = verd_q.pop_front();
                check("verd_pass", pass, ev[38]);
                check("verd_timeout", timeout, ev[37]);
                check("verd_err_count", err_count, ev[36:21]);
                check("verd_min_code", min_code, ev[20:12]);
                check("verd_max_code", max_code, ev[11:3]);
                check("verd_sweep_idx", sweep_idx, ev[2:0]);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        m_active = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!m_active) begin
            model_clear();
            m_active = 1;
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        model_clear();
        m_active = 0;
    endtask

    task automatic send(input int code);
        meas_valid = 1'b1;
        meas_code  = code[CODE_W-1:0];
        model_sample(code);
        tick();
        meas_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_min_code"}, min_code, 9'h1FF);
        check({tag, "_max_code"}, max_code, 0);
        check({tag, "_sweep_idx"}, sweep_idx, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int last_code;
        int code;
        int unsigned r;
        bit aborted;

        do_reset();
        check_idle("reset");

        // Clean two-sweep run.
        do_start();
        check("t1_armed", armed, 1);
        check("t1_min_cleared", min_code, 9'h1FF);
        send(10); send(11); send(12); send(13);
        send(10); send(11); send(13); send(14);
        check("t1_done_latency", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_min", min_code, 10);
        check("t1_max", max_code, 14);
        check("t1_sweep", sweep_idx, 2);

        // Backward and gap violations, restart from DONE.
        do_start();
        check("t2_armed", armed, 1);
        check("t2_err_cleared", err_count, 0);
        check("t2_sweep_cleared", sweep_idx, 0);
        send(10); send(9); send(14); send(15);
        check("t2_err_after_sweep", err_count, 2);
        send(20); send(21); send(22); send(23);
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_err", err_count, 2);

        // Valids in DONE are ignored.
        send(5); send(500);
        check("t6_hold_err", err_count, 2);
        check("t6_hold_min", min_code, 9);
        check("t6_hold_max", max_code, 23);
        check("t6_hold_done", done, 1);
        do_start();
        check("t6_err_cleared", err_count, 0);
        send(30); send(31); send(32); send(33);
        send(34); send(35); send(36); send(37);
        check("t6_pass", pass, 1);

        // Watchdog expiry.
        do_start();
        send(40); send(41);
        model_timeout();
        k = 0;
        while (k < 40 && !done) begin
            tick();
            k++;
        end
        check("t3_timeout_latency", k, TIMEOUT);
        check("t3_timeout", timeout, 1);
        check("t3_pass", pass, 0);

        // Sample arriving on the expiry cycle wins.
        do_start();
        send(40); send(41);
        idle(TIMEOUT - 1);
        send(42);
        check("t3b_no_timeout", timeout, 0);
        check("t3b_armed", armed, 1);
        send(43);
        send(50); send(51); send(52); send(53);
        check("t3b_pass", pass, 1);

        // Abort and reset mid-sweep.
        do_start();
        send(60); send(55); send(70);
        check("t4_err_pre_abort", err_count, 2);
        do_abort();
        check_idle("abort");
        do_start();
        send(60); send(55); send(70);
        do_reset();
        check_idle("rst_mid");

        // Randomized sweeps.
        for (int run = 0; run < 40; run++) begin
            do_start();
            last_code = $urandom_range(0, 400);
            aborted = 0;
            for (int s = 0; s < 20 && m_active; s++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      code = (last_code + $urandom_range(0, 2)) % 512;
                else if (r < 8) code = (last_code + $urandom_range(3, 6)) % 512;
                else            code = $urandom_range(0, 511);
                send(code);
                last_code = code;
                idle($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0 && m_active) do_start();
                if ($urandom_range(0, 29) == 0 && m_active) begin
                    do_abort();
                    aborted = 1;
                end
            end
            if (!aborted && $urandom_range(0, 1) == 1) send($urandom_range(0, 511));
        end

        // Saturation on a long-sweep instance: every sample after the first is an error.
        sat_start = 1'b1;
        tick();
        sat_start = 1'b0;
        sat_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            sat_code = (i % 2 == 1) ? 9'd10 : 9'd20;
            tick();
            if (i == 99)    check("t5_err_99", sat_err, 99);
            if (i == 65535) check("t5_err_at_sat", sat_err, 16'hFFFF);
        end
        sat_valid = 1'b0;
        tick();
        check("t5_err_no_wrap", sat_err, 16'hFFFF);
        check("t5_still_armed", sat_armed, 1);
        check("t5_min", sat_min, 10);
        check("t5_max", sat_max, 20);

        idle(3);
        check("samp_q_drained", samp_q.size(), 0);
        check("verd_q_drained", verd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
